// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding,
// instruction-memory geometry defaults and the default inter-byte timeout.
package inst_loader_pkg;

  localparam int unsigned ROM_SIZE_DEF     = 1024;
  localparam int unsigned ROM_SIZE_BIT_DEF = 10;
  localparam int unsigned IDLE_TIMEOUT_DEF = 1_000_000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  // One instruction-memory word write
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } mem_wr_t;

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master: the loader itself; slave: UART RX source / memory / CPU side.
interface inst_loader_if;

  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        MemWrite;
  logic [31:0] WriteAddress;
  logic [31:0] WriteData;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  start, rx_data, rx_valid,
    output MemWrite, WriteAddress, WriteData, cpu_hold, busy, done, error
  );

  modport slave (
    output start, rx_data, rx_valid,
    input  MemWrite, WriteAddress, WriteData, cpu_hold, busy, done, error
  );

endinterface

// File: rtl/inst_loader_word_pack.sv
// Packs four consecutive bytes into one little-endian 32-bit word.
// word_valid_c_o / word_c_o are combinational: they flag the 4th byte of a
// word in the same cycle it is presented, so the parent can register the write.
module loader_word_pack (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_c_o,
  output logic [31:0] word_c_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;

  // Byte counter and shift register next state; clear drops any partial word
  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clear_i) begin
      cnt_d = 2'd0;
    end else if (byte_valid_i) begin
      cnt_d = 2'(cnt_q + 2'd1);
      sr_d  = {byte_i, sr_q[23:8]};
    end
  end

  // Byte counter and shift register state
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 2'd0;
      sr_q  <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  assign word_valid_c_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);
  assign word_c_o       = {byte_i, sr_q};

endmodule

// File: rtl/inst_loader.sv
// Boot-time instruction-memory writer: parses a length-prefixed byte frame
// from the UART RX path and writes consecutive 32-bit words, holding the CPU
// in reset while loading. Optional feature macro: INST_LOADER_CHECKSUM_EN
// adds a trailing mod-256 checksum byte checked before DONE.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned ROM_SIZE     = ROM_SIZE_DEF,
  parameter int unsigned ROM_SIZE_BIT = ROM_SIZE_BIT_DEF,
  parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  inst_loader_if.master bus
);

  localparam int unsigned TMO_W = $clog2(IDLE_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [7:0]         len_lo_q, len_lo_d;
  logic [15:0]        len_q, len_d;
  logic [15:0]        k_q, k_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  mem_wr_t            wr_q, wr_d;
  logic               mem_write_q, mem_write_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               hold_q, hold_d;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  logic               frame_c;
  logic               tmo_fire_c;
  logic               start_ok_c;
  logic               byte_in_data_c;
  logic               pack_clear_c;
  logic [15:0]        len_n_c;
  logic               last_word_c;
  logic               word_valid_c;
  logic [31:0]        word_c;

  // Frame status and qualifiers derived from the current state
  always_comb begin
    frame_c        = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                     (state_q == S_DATA)   || (state_q == S_CHECK);
    tmo_fire_c     = frame_c && (tmo_q == TMO_W'(IDLE_TIMEOUT));
    start_ok_c     = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                   (state_q == S_ERROR));
    byte_in_data_c = bus.rx_valid && (state_q == S_DATA) && !tmo_fire_c;
    pack_clear_c   = (state_q != S_DATA) || tmo_fire_c;
    len_n_c        = {bus.rx_data, len_lo_q};
    last_word_c    = (k_q == 16'(len_q - 16'd1));
  end

  loader_word_pack u_pack (
    .clk            (clk),
    .rst_i          (reset),
    .clear_i        (pack_clear_c),
    .byte_valid_i   (byte_in_data_c),
    .byte_i         (bus.rx_data),
    .word_valid_c_o (word_valid_c),
    .word_c_o       (word_c)
  );

  // Next-state, word index, timeout, checksum and registered-output logic
  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    k_d         = k_q;
    wr_d        = wr_q;
    mem_write_d = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    // Inter-byte silence counter; saturates at the limit
    if (start_ok_c || bus.rx_valid || !frame_c) begin
      tmo_d = '0;
    end else if (!tmo_fire_c) begin
      tmo_d = TMO_W'(tmo_q + TMO_W'(1));
    end else begin
      tmo_d = tmo_q;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_ok_c) begin
          state_d = S_LEN_LO;
          k_d     = 16'd0;
`ifdef INST_LOADER_CHECKSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end
      S_LEN_LO: begin
        if (tmo_fire_c) begin
          state_d = S_ERROR;
        end else if (bus.rx_valid) begin
          len_lo_d = bus.rx_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (tmo_fire_c) begin
          state_d = S_ERROR;
        end else if (bus.rx_valid) begin
          len_d = len_n_c;
          k_d   = 16'd0;
          if (len_n_c == 16'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end else if ({1'b0, len_n_c} > 17'(ROM_SIZE)) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tmo_fire_c) begin
          state_d = S_ERROR;
        end else begin
`ifdef INST_LOADER_CHECKSUM_EN
          if (byte_in_data_c) begin
            sum_d = 8'(sum_q + bus.rx_data);
          end
`endif
          if (word_valid_c) begin
            mem_write_d = 1'b1;
            wr_d.addr   = 32'({k_q[ROM_SIZE_BIT-1:0], 2'b00});
            wr_d.data   = word_c;
            k_d         = 16'(k_q + 16'd1);
            if (last_word_c) begin
`ifdef INST_LOADER_CHECKSUM_EN
              state_d = S_CHECK;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (tmo_fire_c) begin
          state_d = S_ERROR;
        end else if (bus.rx_valid) begin
          state_d = (bus.rx_data == sum_q) ? S_DONE : S_ERROR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
              (state_d == S_DATA)   || (state_d == S_CHECK);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
    hold_d  = busy_d || error_d;
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_lo_q    <= 8'd0;
      len_q       <= 16'd0;
      k_q         <= 16'd0;
      tmo_q       <= '0;
      wr_q        <= '0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      hold_q      <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      k_q         <= k_d;
      tmo_q       <= tmo_d;
      wr_q        <= wr_d;
      mem_write_q <= mem_write_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      hold_q      <= hold_d;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign bus.MemWrite     = mem_write_q;
  assign bus.WriteAddress = wr_q.addr;
  assign bus.WriteData    = wr_q.data;
  assign bus.cpu_hold     = hold_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader (both with and without
// INST_LOADER_CHECKSUM_EN). Expected writes come from a byte-level model:
// word i = bytes 4i..4i+3 little-endian at byte address 4*i.
module tb_inst_loader;

  localparam int unsigned TO  = 40;
  localparam int unsigned ROM = 1024;
`ifdef INST_LOADER_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        dn;
  } wr_t;

  typedef struct {
    logic [15:0] n;
    int          gapmax;
    bit          poke;
    bit          exp_done;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  wr_t  wq[$];

  inst_loader_if bus ();

  inst_loader #(
    .ROM_SIZE     (ROM),
    .ROM_SIZE_BIT (10),
    .IDLE_TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Record every write strobe together with the done level of that cycle
  always @(negedge clk) begin
    if (bus.MemWrite === 1'b1) wq.push_back('{bus.WriteAddress, bus.WriteData, bus.done});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input bit b, input bit d, input bit e, input bit h);
    chk({tag, "_busy"}, 32'(bus.busy), 32'(b));
    chk({tag, "_done"}, 32'(bus.done), 32'(d));
    chk({tag, "_error"}, 32'(bus.error), 32'(e));
    chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'(h));
  endtask

  // Send one complete frame with random payload and random inter-byte gaps
  task automatic run_frame(input vec_t v, input string tag);
    logic [7:0] data[$];
    logic [7:0] sum;
    logic [7:0] b;
    int         words;
    int         g;
    sum   = 8'd0;
    words = (int'(v.n) <= int'(ROM)) ? int'(v.n) : 0;
    idle(2);
    wq.delete();
    pulse_start();
    chk_flags({tag, "_arm"}, 1'b1, 1'b0, 1'b0, 1'b1);
    put_byte(v.n[7:0]);
    idle($urandom_range(0, v.gapmax));
    put_byte(v.n[15:8]);
    if (int'(v.n) <= int'(ROM)) begin
      for (int i = 0; i < 4 * words; i++) begin
        b = 8'($urandom);
        data.push_back(b);
        sum = 8'(sum + b);
        put_byte(b);
        g = $urandom_range(0, v.gapmax);
        for (int j = 0; j < g; j++) begin
          if (v.poke && j == 0 && $urandom_range(0, 3) == 0) pulse_start();
          else idle(1);
        end
      end
      if (CKS) put_byte(sum);
    end
    idle(2);
    chk_flags({tag, "_end"}, 1'b0, v.exp_done, v.exp_err, v.exp_err);
    chk({tag, "_nwrites"}, 32'(wq.size()), 32'(v.exp_writes));
    for (int i = 0; i < wq.size() && i < words; i++) begin
      chk({tag, "_addr"}, wq[i].a, 32'(4 * i));
      chk({tag, "_data"}, wq[i].d, {data[4*i+3], data[4*i+2], data[4*i+1], data[4*i]});
      chk({tag, "_done_at_wr"}, 32'(wq[i].dn), 32'(!CKS && i == words - 1));
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t rv;
    vecs[0] = '{16'd0,     2, 1'b0, 1'b1, 1'b0, 0};
    vecs[1] = '{16'd1,     0, 1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{16'd3,     3, 1'b1, 1'b1, 1'b0, 3};
    vecs[3] = '{16'd1024,  0, 1'b0, 1'b1, 1'b0, 1024};
    vecs[4] = '{16'd1025,  1, 1'b0, 1'b0, 1'b1, 0};
    vecs[5] = '{16'hFFFF,  1, 1'b0, 1'b0, 1'b1, 0};

    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;

    // Reset state
    #2 reset = 1'b1;
    #2;
    chk("rst_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("rst_addr", bus.WriteAddress, 32'd0);
    chk("rst_data", bus.WriteData, 32'd0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    reset = 1'b0;
    idle(2);

    // Two-word program
    wq.delete();
    pulse_start();
    chk_flags("p2_arm", 1'b1, 1'b0, 1'b0, 1'b1);
    put_byte(8'h02); put_byte(8'h00);
    put_byte(8'h13); put_byte(8'h00); put_byte(8'h00); put_byte(8'h00);
    put_byte(8'h93); put_byte(8'h00); put_byte(8'h10); put_byte(8'h00);
    if (CKS) put_byte(8'hB6);
    idle(2);
    chk("p2_nwrites", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      chk("p2_a0", wq[0].a, 32'h0);
      chk("p2_d0", wq[0].d, 32'h00000013);
      chk("p2_a1", wq[1].a, 32'h4);
      chk("p2_d1", wq[1].d, 32'h00100093);
      chk("p2_done_at_last_wr", 32'(wq[1].dn), 32'(!CKS));
    end
    chk_flags("p2_end", 1'b0, 1'b1, 1'b0, 1'b0);

    // Bytes arriving in DONE are ignored
    wq.delete();
    repeat (4) put_byte(8'hAA);
    idle(2);
    chk("ign_nwrites", 32'(wq.size()), 32'd0);
    chk_flags("ign", 1'b0, 1'b1, 1'b0, 1'b0);

    // Empty frame: done right after the second length byte
    wq.delete();
    pulse_start();
    put_byte(8'h00);
    chk_flags("n0_lo", 1'b1, 1'b0, 1'b0, 1'b1);
    put_byte(8'h00);
    chk_flags("n0_hi", CKS, !CKS, 1'b0, CKS);
    if (CKS) begin
      put_byte(8'h00);
      chk_flags("n0_cks", 1'b0, 1'b1, 1'b0, 1'b0);
    end
    idle(2);
    chk("n0_nwrites", 32'(wq.size()), 32'd0);

    // Oversized length aborts, then a new start re-arms
    wq.delete();
    pulse_start();
    put_byte(8'h01); put_byte(8'h04);
    chk_flags("big", 1'b0, 1'b0, 1'b1, 1'b1);
    pulse_start();
    chk_flags("big_rearm", 1'b1, 1'b0, 1'b0, 1'b1);
    put_byte(8'h00); put_byte(8'h00);
    if (CKS) put_byte(8'h00);
    idle(2);
    chk("big_nwrites", 32'(wq.size()), 32'd0);
    chk_flags("big_end", 1'b0, 1'b1, 1'b0, 1'b0);

    // Inter-byte timeout in DATA with a partial word
    wq.delete();
    pulse_start();
    put_byte(8'h01); put_byte(8'h00); put_byte(8'h13); put_byte(8'h00);
    idle(TO);
    chk_flags("tmo_edge", 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk_flags("tmo_fire", 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    chk("tmo_nwrites", 32'(wq.size()), 32'd0);

    // Asynchronous reset mid-DATA with a partial word pending
    wq.delete();
    pulse_start();
    put_byte(8'h04); put_byte(8'h00);
    for (int i = 0; i < 8; i++) put_byte(8'(8'h21 + i));
    put_byte(8'h77);
    idle(1);
    chk("mid_nwrites", 32'(wq.size()), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("mrst_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("mrst_addr", bus.WriteAddress, 32'd0);
    chk("mrst_data", bus.WriteData, 32'd0);
    chk_flags("mrst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    rv = '{16'd2, 1, 1'b0, 1'b1, 1'b0, 2};
    run_frame(rv, "after_rst");

`ifdef INST_LOADER_CHECKSUM_EN
    // Checksum match and mismatch
    wq.delete();
    pulse_start();
    put_byte(8'h01); put_byte(8'h00);
    put_byte(8'h01); put_byte(8'h02); put_byte(8'h03); put_byte(8'h04);
    chk("ck_wr_strobe", 32'(bus.MemWrite), 32'd1);
    chk_flags("ck_wait", 1'b1, 1'b0, 1'b0, 1'b1);
    put_byte(8'h0A);
    idle(2);
    chk("ck_nwrites", 32'(wq.size()), 32'd1);
    if (wq.size() == 1) chk("ck_data", wq[0].d, 32'h04030201);
    chk_flags("ck_ok", 1'b0, 1'b1, 1'b0, 1'b0);
    wq.delete();
    pulse_start();
    put_byte(8'h01); put_byte(8'h00);
    put_byte(8'h01); put_byte(8'h02); put_byte(8'h03); put_byte(8'h04);
    put_byte(8'h0B);
    idle(2);
    chk("ckbad_nwrites", 32'(wq.size()), 32'd1);
    chk_flags("ckbad", 1'b0, 1'b0, 1'b1, 1'b1);
`endif

    // Table-driven frames
    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Randomized frames with gaps and stray start pulses
    for (int i = 0; i < 12; i++) begin
      rv.n          = 16'($urandom_range(0, 6));
      rv.gapmax     = 3;
      rv.poke       = 1'b1;
      rv.exp_done   = 1'b1;
      rv.exp_err    = 1'b0;
      rv.exp_writes = int'(rv.n);
      run_frame(rv, $sformatf("rnd%0d", i));
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
